// File: rtl/slave_bus_sequencer.sv
// Sequences CPU accesses to the 68HC05 slave window: IRQ pulse, DTACK wait, ack.
// Optional build macro SLAVE_TIMEOUT_EN adds a WAIT_DTACK timeout with bus_err.
module slave_bus_sequencer #(
    parameter int IRQ_PULSE_LEN  = 20,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        write_strobe,
    input  logic        uds,
    input  logic        lds,
    input  logic [1:0]  addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        bus_ack,
    output logic        bus_err,
    output logic        busy,
    output logic [7:0]  slave_porta_in,
    input  logic [7:0]  slave_porta_out,
    output logic [1:0]  slave_addr,
    output logic        slave_write_n,
    input  logic        slave_dtack,
    output logic        slave_irq_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IRQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    localparam logic [7:0] IRQ_LEN = 8'(IRQ_PULSE_LEN);

    if (IRQ_PULSE_LEN < 1 || IRQ_PULSE_LEN > 255) begin : g_bad_irq
        $error("IRQ_PULSE_LEN must be 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be 1..8191");
    end

    logic [1:0] state;
    logic [7:0] cnt;
    logic       cs_q;
    logic       dtack_q;
    logic       dtack_pend;
    logic [7:0] pend_data;
    logic [7:0] rdata;
    logic       start;
    logic       rise;
    logic       trigger;
    logic       to_fire;
    logic       unused_hi;

    assign start     = cs & ~cs_q & (uds | lds);
    assign rise      = slave_dtack & ~dtack_q;
    assign trigger   = rise | dtack_pend;
    assign busy      = (state != S_IDLE);
    assign cpu_dout  = {rdata, rdata};
    assign unused_hi = ^cpu_din[15:8];

`ifdef SLAVE_TIMEOUT_EN
    localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYCLES - 1);

    logic [12:0] to_cnt;

    assign to_fire = (state == S_WAIT) & cs & ~trigger & (to_cnt == TO_LAST);

    // Counter is held at zero outside WAIT_DTACK, so it restarts on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= 13'd0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= to_fire;
            if (state == S_WAIT) begin
                to_cnt <= to_cnt + 13'd1;
            end else begin
                to_cnt <= 13'd0;
            end
        end
    end
`else
    assign to_fire = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= 8'd0;
            cs_q           <= 1'b0;
            dtack_q        <= 1'b0;
            dtack_pend     <= 1'b0;
            pend_data      <= 8'd0;
            rdata          <= 8'd0;
            bus_ack        <= 1'b0;
            slave_porta_in <= 8'hFF;
            slave_addr     <= 2'd0;
            slave_write_n  <= 1'b1;
            slave_irq_n    <= 1'b1;
        end else begin
            cs_q    <= cs;
            dtack_q <= slave_dtack;
            bus_ack <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        slave_addr     <= addr;
                        slave_porta_in <= cpu_din[7:0];
                        slave_write_n  <= ~write_strobe;
                        cnt            <= IRQ_LEN;
                        slave_irq_n    <= 1'b0;
                        state          <= S_IRQ;
                    end
                end
                S_IRQ: begin
                    if (!cs) begin
                        slave_irq_n <= 1'b1;
                        dtack_pend  <= 1'b0;
                        cnt         <= 8'd0;
                        state       <= S_IDLE;
                    end else begin
                        // Early DTACK: keep the byte from the first edge only.
                        if (rise && !dtack_pend) begin
                            dtack_pend <= 1'b1;
                            pend_data  <= slave_porta_out;
                        end
                        if (cnt == 8'd1) begin
                            slave_irq_n <= 1'b1;
                            cnt         <= 8'd0;
                            state       <= S_WAIT;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!cs) begin
                        dtack_pend <= 1'b0;
                        state      <= S_IDLE;
                    end else if (trigger) begin
                        rdata   <= dtack_pend ? pend_data : slave_porta_out;
                        bus_ack <= 1'b1;
                        state   <= S_REL;
                    end else if (to_fire) begin
                        state <= S_REL;
                    end
                end
                S_REL: begin
                    if (!cs) begin
                        dtack_pend <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
